// File: rtl/count_seq_checker_pkg.sv
// Shared types and constants for the upstream counter sequence checker.
// The helper predicts the counter's next value from its last sample and reset.
package count_seq_checker_pkg;

    localparam int CNT_W    = 4;
    localparam int STAT_W   = 8;
    localparam int LOCK_RUN = 4;
    localparam int RUN_W    = $clog2(LOCK_RUN);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] expected_next(
        input logic [CNT_W-1:0] prev,
        input logic             cnt_rst
    );
        return cnt_rst ? '0 : prev + CNT_W'(1);
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Event counter that either saturates at all-ones or wraps modulo 2**W.
// Counts one per cycle while inc_i is high; synchronous active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         sat_en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(sat_en_i && (count_q == {W{1'b1}}))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Watches a free-running 4-bit counter, locks after a run of correct samples,
// then flags sequence violations and counts natural 15->0 wraps.
module count_seq_checker
    import count_seq_checker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  q_in,
    input  logic              cnt_rst_in,
    output logic              locked,
    output logic              seq_err,
    output logic [STAT_W-1:0] err_count,
    output logic              wrap_pulse,
    output logic [STAT_W-1:0] wrap_count,
    output state_e            state_dbg
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   prev_q;
    logic               cnt_rst_q;
    logic [RUN_W-1:0]   good_run_q, good_run_d;
    logic               locked_q, seq_err_q, seq_err_d, wrap_pulse_q, wrap_pulse_d;
    logic               err_inc, wrap_inc;
    logic               match;
    logic               natural_wrap;

    assign match        = (q_in == expected_next(prev_q, cnt_rst_q));
    // A 15->0 step is a wrap only when the counter was not being reset.
    assign natural_wrap = (prev_q == {CNT_W{1'b1}}) && (q_in == '0) && !cnt_rst_q;

    always_comb begin
        state_d      = state_q;
        good_run_d   = good_run_q;
        seq_err_d    = 1'b0;
        wrap_pulse_d = 1'b0;
        err_inc      = 1'b0;
        wrap_inc     = 1'b0;
        case (state_q)
            SYNC: begin
                state_d    = CHECK;
                good_run_d = '0;
            end
            CHECK: begin
                if (!match) begin
                    good_run_d = '0;
                end else if (good_run_q == RUN_W'(LOCK_RUN - 1)) begin
                    state_d    = LOCKED;
                    good_run_d = '0;
                end else begin
                    good_run_d = good_run_q + RUN_W'(1);
                end
            end
            LOCKED: begin
                if (!match) begin
                    seq_err_d  = 1'b1;
                    err_inc    = 1'b1;
                    state_d    = CHECK;
                    good_run_d = '0;
                end else if (natural_wrap) begin
                    wrap_pulse_d = 1'b1;
                    wrap_inc     = 1'b1;
                end
            end
            default: begin
                state_d    = SYNC;
                good_run_d = '0;
            end
        endcase
    end

    // Every sample becomes the reference for the next one, in all states.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            prev_q       <= '0;
            cnt_rst_q    <= 1'b0;
            good_run_q   <= '0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= q_in;
            cnt_rst_q    <= cnt_rst_in;
            good_run_q   <= good_run_d;
            locked_q     <= (state_d == LOCKED);
            seq_err_q    <= seq_err_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .inc_i    (err_inc),
        .sat_en_i (1'b1),
        .count_o  (err_count)
    );

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .inc_i    (wrap_inc),
        .sat_en_i (1'b0),
        .count_o  (wrap_count)
    );

    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign wrap_pulse = wrap_pulse_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed and randomized bench for count_seq_checker with a behavioural
// model of the lock/violation/wrap rules.
module tb_count_seq_checker;
  import count_seq_checker_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  q_in = 4'd0;
  logic        cnt_rst_in = 1'b0;
  logic        locked;
  logic        seq_err;
  logic [7:0]  err_count;
  logic        wrap_pulse;
  logic [7:0]  wrap_count;
  state_e      state_dbg;

  always #5 clk = ~clk;

  count_seq_checker dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .cnt_rst_in (cnt_rst_in),
    .locked     (locked),
    .seq_err    (seq_err),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .state_dbg  (state_dbg)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned seq_pulses = 0;
  int unsigned wrap_pulses = 0;

  // reference model: last sample, run of consecutive matches, lock flag
  int m_prev = 0;
  int m_rst = 0;
  int m_run = 0;
  int m_errs = 0;
  int m_wraps = 0;
  bit m_locked = 1'b0;
  bit m_have_prev = 1'b0;
  bit e_seq = 1'b0;
  bit e_wrap = 1'b0;

  logic [3:0] cnt = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_rst = 0; m_run = 0; m_errs = 0; m_wraps = 0;
    m_locked = 1'b0; m_have_prev = 1'b0; e_seq = 1'b0; e_wrap = 1'b0;
  endtask

  task automatic model_step(input int q, input int r);
    int want;
    e_seq = 1'b0;
    e_wrap = 1'b0;
    if (!m_have_prev) begin
      m_have_prev = 1'b1;
      m_run = 0;
    end else begin
      want = (m_rst != 0) ? 0 : (m_prev + 1) % 16;
      if (q == want) begin
        if (m_locked) begin
          if (m_prev == 15 && q == 0 && m_rst == 0) begin
            e_wrap = 1'b1;
            m_wraps = (m_wraps + 1) % 256;
          end
        end else begin
          m_run++;
          if (m_run >= 4) m_locked = 1'b1;
        end
      end else begin
        if (m_locked) begin
          e_seq = 1'b1;
          m_errs = (m_errs < 255) ? m_errs + 1 : 255;
          m_locked = 1'b0;
        end
        m_run = 0;
      end
    end
    m_prev = q;
    m_rst = r;
  endtask

  task automatic check_outputs();
    state_e exp_state;
    if (m_locked) exp_state = LOCKED;
    else if (!m_have_prev) exp_state = SYNC;
    else exp_state = CHECK;
    check("locked", 32'(locked), 32'(m_locked));
    check("seq_err", 32'(seq_err), 32'(e_seq));
    check("err_count", 32'(err_count), 32'(m_errs));
    check("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
    check("wrap_count", 32'(wrap_count), 32'(m_wraps));
    check("state", 32'(state_dbg), 32'(exp_state));
    if (seq_err) seq_pulses++;
    if (wrap_pulse) wrap_pulses++;
  endtask

  task automatic step(input logic rst, input logic [3:0] q, input logic r);
    @(negedge clk);
    reset = rst;
    q_in = q;
    cnt_rst_in = r;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(int'(q), int'(r));
    #1;
    check_outputs();
  endtask

  task automatic good(input logic r);
    step(1'b0, cnt, r);
    cnt = r ? 4'd0 : cnt + 4'd1;
  endtask

  task automatic bad();
    logic [3:0] want;
    logic [3:0] q;
    want = (m_rst != 0) ? 4'd0 : 4'(m_prev + 1);
    q = want + 4'($urandom_range(1, 15));
    step(1'b0, q, 1'b0);
    cnt = q + 4'd1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'd0, 1'b0);
    cnt = 4'd0;
  endtask

  initial begin
    int unsigned p0;

    // reset for two cycles, everything cleared
    do_reset();
    do_reset();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(SYNC));

    // lock rises after the fifth edge past reset
    for (int i = 0; i < 4; i++) good(1'b0);
    check("lock_not_yet", 32'(locked), 32'd0);
    good(1'b0);
    check("lock_after_5", 32'(locked), 32'd1);

    // reset-induced return to 0, then 40 cycles from q_in=0 give two wraps
    good(1'b1);
    p0 = wrap_pulses;
    for (int i = 0; i < 40; i++) good(1'b0);
    check("wrap_pulses_40", wrap_pulses - p0, 32'd2);
    check("wrap_count_40", 32'(wrap_count), 32'd2);

    // counter reset at 7 is a match, not a violation
    for (int i = 0; i < 16 && cnt != 4'd7; i++) good(1'b0);
    good(1'b1);
    good(1'b0);
    check("rst7_seq_err", 32'(seq_err), 32'd0);
    check("rst7_wrap", 32'(wrap_pulse), 32'd0);
    check("rst7_locked", 32'(locked), 32'd1);

    // 15->0 caused by counter reset is not a wrap
    for (int i = 0; i < 16 && cnt != 4'd15; i++) good(1'b0);
    good(1'b1);
    good(1'b0);
    check("rst15_wrap", 32'(wrap_pulse), 32'd0);
    check("rst15_locked", 32'(locked), 32'd1);

    // 5 then 9 while locked
    for (int i = 0; i < 16 && cnt != 4'd5; i++) good(1'b0);
    good(1'b0);
    step(1'b0, 4'd9, 1'b0);
    cnt = 4'd10;
    check("viol_seq_err", 32'(seq_err), 32'd1);
    check("viol_err_count", 32'(err_count), 32'd1);
    check("viol_locked", 32'(locked), 32'd0);
    good(1'b0);
    check("viol_pulse_once", 32'(seq_err), 32'd0);
    good(1'b0);
    good(1'b0);
    check("relock_not_yet", 32'(locked), 32'd0);
    good(1'b0);
    check("relock_after_4", 32'(locked), 32'd1);

    // build err_count=3, wrap_count=10, then reset during a violation
    do_reset();
    for (int i = 0; i < 5; i++) good(1'b0);
    for (int v = 0; v < 3; v++) begin
      bad();
      for (int i = 0; i < 4; i++) good(1'b0);
    end
    for (int i = 0; i < 400 && m_wraps < 10; i++) good(1'b0);
    check("pre_rst_err", 32'(err_count), 32'd3);
    check("pre_rst_wrap", 32'(wrap_count), 32'd10);
    check("pre_rst_locked", 32'(locked), 32'd1);
    step(1'b1, cnt + 4'd3, 1'b0);
    cnt = 4'd0;
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_wrap", 32'(wrap_count), 32'd0);
    check("mid_rst_seq", 32'(seq_err), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(SYNC));

    // 300 violations with relock: saturation of err_count
    for (int i = 0; i < 5; i++) good(1'b0);
    p0 = seq_pulses;
    for (int v = 0; v < 300; v++) begin
      bad();
      for (int i = 0; i < 4; i++) good(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    check("sat_pulses", seq_pulses - p0, 32'd300);
    check("sat_err_count", 32'(err_count), 32'd255);

    // random mix of good samples, counter resets and arbitrary values
    for (int i = 0; i < 400; i++) begin
      int unsigned pick;
      logic [3:0] rq;
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        rq = 4'($urandom_range(0, 15));
        step(1'b0, rq, 1'b0);
        cnt = rq + 4'd1;
      end else if (pick == 1) begin
        good(1'b1);
      end else begin
        good(1'b0);
      end
    end

    do_reset();
    check("final_rst_err", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset of this block.
REQ-003 q_in  input  4  value of the upstream 4-bit free-running counter (0..15, increments by 1 per cycle, wraps 15->0).
REQ-004 cnt_rst_in  input  1  the synchronous reset driven to the upstream counter, sampled to predict its next value.
REQ-005 locked  output  1  high while checker is in LOCKED state.
REQ-006 seq_err  output  1  one-cycle pulse flagging a sequence violation while locked.
REQ-007 err_count  output  8  number of violations, saturating at 255.
REQ-008 wrap_pulse  output  1  one-cycle pulse on each natural 15->0 wrap seen while locked.
REQ-009 wrap_count  output  8  number of natural wraps while locked, modulo 256.

Function
REQ-010 The block SHALL sample q_in and cnt_rst_in every rising edge; all outputs SHALL be registered, so the outcome of the sample at edge k SHALL be visible after edge k (1-cycle latency).
REQ-011 The block SHALL hold prev (last sampled q_in, 4 bits) and rst_d (last sampled cnt_rst_in).
REQ-012 Expected value SHALL be 0 when rst_d=1, else (prev+1) mod 16; a sample matches when q_in equals expected.
REQ-013 The FSM SHALL have states SYNC, CHECK, LOCKED.
REQ-014 SYNC: capture prev/rst_d, no comparison, next state CHECK with good_run=0.
REQ-015 CHECK: on match, good_run increments; when good_run reaches 3 and the current sample matches (4th consecutive match), next state LOCKED; on mismatch, good_run SHALL clear with no seq_err and no err_count change.
REQ-016 LOCKED: match stays LOCKED; mismatch SHALL pulse seq_err, increment err_count (saturating at 255), and move to CHECK with good_run=0.
REQ-017 A natural wrap SHALL be prev=15, q_in=0, rst_d=0, in LOCKED; it SHALL pulse wrap_pulse and increment wrap_count (255->0).
REQ-018 prev=15, q_in=0 with rst_d=1 SHALL be a reset-induced match, not a wrap.
REQ-019 A mismatch that is also 15->0 is impossible by REQ-012; no special case needed.
REQ-020 The sample that causes LOCKED->CHECK SHALL become prev; the next comparison uses it.
REQ-021 seq_err and wrap_pulse SHALL never be high for more than one cycle per offending sample.
REQ-022 err_count at 255 SHALL stay 255 on further violations; seq_err still pulses.

Reset
REQ-023 With reset=1 at an edge: state=SYNC, prev=0, rst_d=0, good_run=0, locked=0, seq_err=0, err_count=0, wrap_pulse=0, wrap_count=0.
REQ-024 Reset SHALL override all other activity, including mid-LOCKED and coincident with a violation.

Structure
REQ-025 A shared package SHALL hold the state enum (SYNC/CHECK/LOCKED), LOCK_RUN=4, CNT_W=4, STAT_W=8.
REQ-026 One sub-module, sat_counter (width parameter, inc, saturate-enable), SHALL implement err_count (saturating) and wrap_count (modulo).

Verification
REQ-027 Reset 2 cycles, then counter runs from 0 with cnt_rst_in=0 -> locked rises after 5th edge past reset, seq_err stays 0.
REQ-028 Locked, run 40 cycles from q_in=0 -> wrap_pulse twice (at the 15->0 transitions), wrap_count=2.
REQ-029 Locked at q_in=7, drive cnt_rst_in=1 one cycle, q_in=0 next -> no seq_err, no wrap_pulse, stays locked.
REQ-030 Locked, force q_in 5 then 9 -> seq_err one pulse, err_count=1, locked=0; locked returns after 4 further good samples.
REQ-031 Inject 300 violations, each followed by relock -> err_count=255, seq_err pulsed 300 times.
REQ-032 Assert reset while locked with err_count=3, wrap_count=10 -> all outputs 0 after the edge, state SYNC.
